// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser and per-bit stability filter for board slide switches.
// Drives registered clean levels and one-cycle rise/fall event pulses.
module sw_debounce #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_clean,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             changed
);

    // STABLE: synchronised bit agrees with the clean level; COUNTING: it disagrees.
    typedef enum logic {
        STABLE   = 1'b0,
        COUNTING = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] s;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] clean_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;
    state_t           state   [WIDTH];

    // NOTE: sequential state is only ever written with non-blocking assignments so every
    // register samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            s        <= '0;
            sw_clean <= '0;
            sw_rise  <= '0;
            sw_fall  <= '0;
            // NOTE: the counter array is reset too, so a reset mid-count discards all progress.
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= sw_raw;
            s        <= sync1;
            sw_clean <= clean_nxt;
            sw_rise  <= rise_nxt;
            sw_fall  <= fall_nxt;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        clean_nxt = sw_clean;
        rise_nxt  = '0;
        fall_nxt  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            state[i]   = (s[i] == sw_clean[i]) ? STABLE : COUNTING;
            case (state[i])
                STABLE: begin
                    cnt_nxt[i] = '0;
                end
                COUNTING: begin
                    if (cnt[i] == CNT_LAST) begin
                        clean_nxt[i] = s[i];
                        rise_nxt[i]  = s[i];
                        fall_nxt[i]  = ~s[i];
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_nxt[i] = '0;
                end
            endcase
        end
    end

    assign changed = |(sw_rise | sw_fall);

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: directed scenarios with literal expectations plus
// randomised switch activity compared every cycle against a sliding-window reference model.
module tb_sw_debounce;

    localparam int W = 8;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] sw_raw = '0;
    logic [W-1:0] sw_clean;
    logic [W-1:0] sw_rise;
    logic [W-1:0] sw_fall;
    logic         changed;

    int n_tests = 0;
    int n_fail  = 0;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S), .CNT_W(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .sw_raw   (sw_raw),
        .sw_clean (sw_clean),
        .sw_rise  (sw_rise),
        .sw_fall  (sw_fall),
        .changed  (changed)
    );

    always #5 clk = ~clk;

    // Reference model: hist[k] is the raw value sampled k+1 edges ago. The synchronised value
    // seen at an edge is the raw value from two edges earlier, so a bit's clean level flips
    // when the last S synchronised samples all disagree with it.
    logic [W-1:0] hist [8];
    logic [W-1:0] m_clean = '0;
    logic [W-1:0] m_rise  = '0;
    logic [W-1:0] m_fall  = '0;
    logic         all_diff;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < 8; j++) hist[j] = '0;
            m_clean = '0;
            m_rise  = '0;
            m_fall  = '0;
        end else begin
            m_rise = '0;
            m_fall = '0;
            for (int b = 0; b < W; b++) begin
                all_diff = 1'b1;
                for (int j = 1; j <= S; j++)
                    if (hist[j][b] == m_clean[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_clean[b] = ~m_clean[b];
                    if (m_clean[b]) m_rise[b] = 1'b1;
                    else            m_fall[b] = 1'b1;
                end
            end
            for (int j = 7; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = sw_raw;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model on every out-of-reset cycle.
    always @(negedge clk) begin
        if (!rst) begin
            check("model", {8'h0, sw_clean, sw_rise, sw_fall} | {31'h0, changed} << 31,
                  {8'h0, m_clean, m_rise, m_fall} | {31'h0, |(m_rise | m_fall)} << 31);
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive raw at a negedge and hold it; verify nothing moves for five edges and the
    // expected clean level and pulses appear right after the sixth.
    task automatic settle(input string name, input logic [W-1:0] raw,
                          input logic [W-1:0] old_clean, input logic [W-1:0] exp_clean,
                          input logic [W-1:0] exp_rise, input logic [W-1:0] exp_fall);
        sw_raw = raw;
        wait_neg(5);
        check({name, "_hold"}, sw_clean, old_clean);
        wait_neg(1);
        check({name, "_clean"}, sw_clean, exp_clean);
        check({name, "_rise"}, sw_rise, exp_rise);
        check({name, "_fall"}, sw_fall, exp_fall);
        check({name, "_changed"}, changed, 1);
        wait_neg(1);
        check({name, "_pulse_end"}, sw_rise | sw_fall, 0);
        check({name, "_changed_end"}, changed, 0);
    endtask

    initial begin
        int r;
        wait_neg(3);
        #1 rst = 1'b0;
        wait_neg(2);
        check("after_reset_clean", sw_clean, 8'h00);

        // Clean rise on bit 0.
        settle("rise", 8'h01, 8'h00, 8'h01, 8'h01, 8'h00);

        // Bounce on bit 1, then hold high.
        sw_raw = 8'h03; wait_neg(1);
        sw_raw = 8'h01; wait_neg(1);
        sw_raw = 8'h03; wait_neg(1);
        sw_raw = 8'h01; wait_neg(1);
        check("bounce_clean", sw_clean, 8'h01);
        check("bounce_nopulse", sw_rise | sw_fall, 8'h00);
        settle("bounce", 8'h03, 8'h01, 8'h03, 8'h02, 8'h00);

        // Reach 0C, then fall to 00.
        settle("to0c", 8'h0C, 8'h03, 8'h0C, 8'h0C, 8'h03);
        settle("fall", 8'h00, 8'h0C, 8'h00, 8'h00, 8'h0C);

        // Simultaneous multi-bit rise.
        settle("multi", 8'hA5, 8'h00, 8'hA5, 8'hA5, 8'h00);

        // Asynchronous reset mid-cycle with counters running.
        sw_raw = 8'hFF;
        wait_neg(3);
        #1 rst = 1'b1;
        #1;
        check("rst_clean", sw_clean, 8'h00);
        check("rst_rise", sw_rise, 8'h00);
        check("rst_fall", sw_fall, 8'h00);
        check("rst_changed", changed, 0);

        // Reset mid-count with bit 7 held high.
        sw_raw = 8'h80;
        wait_neg(1);
        #1 rst = 1'b0;
        wait_neg(3);
        check("midcnt_pre", sw_clean, 8'h00);
        #1 rst = 1'b1;
        wait_neg(1);
        #1 rst = 1'b0;
        wait_neg(5);
        check("midcnt_hold", sw_clean, 8'h00);
        check("midcnt_nopulse", sw_rise, 8'h00);
        wait_neg(1);
        check("midcnt_clean", sw_clean, 8'h80);
        check("midcnt_rise", sw_rise, 8'h80);
        wait_neg(1);
        check("midcnt_rise_end", sw_rise, 8'h00);

        // Randomised activity: occasional new words, single-bit bounces and rare resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            r = int'($urandom_range(0, 99));
            if (r < 8)       sw_raw = W'($urandom);
            else if (r < 20) sw_raw = sw_raw ^ (W'(1) << $urandom_range(0, W - 1));
            if ($urandom_range(0, 299) == 0) begin
                #1 rst = 1'b1;
                @(negedge clk);
                #1 rst = 1'b0;
            end
        end

        wait_neg(10);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
